// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - N-channel valid/ready merge with round-robin or forced-select arbitration
//
// Purpose:
//   Merges N producer channels of WIDTH bits onto one registered output
//   stream. mode_i=0 arbitrates round-robin among valid channels; mode_i=1
//   lets only channel sel_i pass. The output register captures a new word
//   whenever it is empty or being drained, so throughput is one word/cycle.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         asynchronous active-high reset
//   in_data_i     N*WIDTH channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid_i    per-channel valid
//   in_ready_o    per-channel ready (combinational, one-hot or zero)
//   mode_i        0 = round-robin, 1 = forced select
//   sel_i         channel index used when mode_i=1 (>= N selects nothing)
//   out_data_o    registered output data
//   out_valid_o   registered output valid
//   out_ready_i   downstream ready
//   out_chan_o    channel index of the word held in the output register
//
// Optional (macro RR_MUX_ARBITER_STATS_EN):
//   stats_clr_i   synchronous clear of all grant counters (wins over increment)
//   grant_count_o N*16 per-channel transfer counters, channel i at [i*16 +: 16]

module rr_mux_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  input  logic [N-1:0]       in_valid_i,
  output logic [N-1:0]       in_ready_o,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [WIDTH-1:0]   out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [SEL_W-1:0]   out_chan_o
`ifdef RR_MUX_ARBITER_STATS_EN
  ,
  input  logic               stats_clr_i,
  output logic [N*16-1:0]    grant_count_o
`endif
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;

  logic             load;
  logic [N-1:0]     elig;
  logic             found;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  // The output register can take a word when empty or when its word leaves now.
  assign load = ~out_valid_q | out_ready_i;

  // In forced-select mode only the channel whose index equals sel_i may be
  // eligible; an out-of-range sel_i matches no channel.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      if (!mode_i) begin
        elig[i] = in_valid_i[i];
      end else if (sel_i == SEL_W'(i)) begin
        elig[i] = in_valid_i[i];
      end
    end
  end

  // Rotating search starting just after the last granted channel.
  always_comb begin
    int idx;
    idx        = 0;
    found      = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant_idx  = SEL_W'(idx);
        grant_data = in_data_i[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Eligible implies valid, so a granted ready always completes a transfer.
  assign xfer = load & found;

  always_comb begin
    in_ready_o = '0;
    for (int i = 0; i < N; i++) begin
      in_ready_o[i] = xfer && (grant_idx == SEL_W'(i));
    end
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_chan_d   = out_chan_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      out_data_d   = grant_data;
      out_valid_d  = 1'b1;
      out_chan_d   = grant_idx;
      last_grant_d = grant_idx;
    end else if (out_ready_i) begin
      // Drained with nothing to replace it; data and channel keep their values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_chan_q   <= '0;
      // Pointer at N-1 so channel 0 is searched first after reset.
      last_grant_q <= SEL_W'(N - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_chan_q   <= out_chan_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_chan_o  = out_chan_q;

`ifdef RR_MUX_ARBITER_STATS_EN
  logic [15:0] cnt_q [N];
  logic [15:0] cnt_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr_i) begin
        cnt_d[i] = '0;
      end else if (xfer && (grant_idx == SEL_W'(i))) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    grant_count_o = '0;
    for (int i = 0; i < N; i++) begin
      grant_count_o[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - self-checking bench for rr_mux_arbiter (WIDTH=8, N=4)

module tb_rr_mux_arbiter;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_chan;
`ifdef RR_MUX_ARBITER_STATS_EN
  logic               stats_clr;
  logic [N*16-1:0]    grant_count;
`endif

  rr_mux_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_data_i     (in_data),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .mode_i        (mode),
    .sel_i         (sel),
    .out_data_o    (out_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_chan_o    (out_chan)
`ifdef RR_MUX_ARBITER_STATS_EN
    ,
    .stats_clr_i   (stats_clr),
    .grant_count_o (grant_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the output register's contents plus the rotation pointer.
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  int               m_chan  = 0;
  int               m_last  = N - 1;
  int               m_cnt [N];

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  end

  // First eligible channel when looking at last+1, last+2, ... modulo N.
  function automatic int model_winner();
    for (int off = 1; off <= N; off++) begin
      int ch;
      ch = (m_last + off) % N;
      if (in_valid[ch] && (!mode || int'(sel) == ch)) return ch;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= 0;
      m_last  <= N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
    end else begin
      w = model_winner();
      if ((!m_valid || out_ready) && w >= 0) begin
        m_valid  <= 1'b1;
        m_data   <= in_data[w*WIDTH +: WIDTH];
        m_chan   <= w;
        m_last   <= w;
        m_cnt[w] <= (m_cnt[w] + 1) % 65536;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int w;
    logic [N-1:0] er;
    w  = model_winner();
    er = '0;
    if ((!m_valid || out_ready) && w >= 0) er[w] = 1'b1;
    check("model_in_ready", 32'(in_ready), 32'(er));
    check("model_out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("model_out_data", 32'(out_data), 32'(m_data));
      check("model_out_chan", 32'(out_chan), 32'(m_chan));
    end
`ifdef RR_MUX_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) begin
      check("model_grant_count", 32'(grant_count[i*16 +: 16]), 32'(m_cnt[i]));
    end
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pat  [4];
  int         skip [4];

  initial begin
    pat[0] = 8'hA0; pat[1] = 8'hB1; pat[2] = 8'hC2; pat[3] = 8'hD3;
    skip[0] = 1; skip[1] = 3; skip[2] = 1; skip[3] = 3;

    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
`ifdef RR_MUX_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    rst = 1'b1;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_out_data", 32'(out_data), 32'h00);
    check("reset_out_chan", 32'(out_chan), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h0);

    // Round-robin fairness with everyone valid
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_chan", 32'(out_chan), 32'(i % 4));
      check("rr_data", 32'(out_data), 32'(pat[i % 4]));
      check("rr_valid", 32'(out_valid), 32'h1);
    end

    // Only channels 1 and 3 valid; pointer sits at 3
    in_valid = 4'b1010;
    #1;
    check("skip_first_ready", 32'(in_ready), 32'h2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("skip_chan", 32'(out_chan), 32'(skip[i]));
      check("skip_rdy_0_2", 32'({in_ready[2], in_ready[0]}), 32'h0);
    end

    // Backpressure right after capturing 0xB1
    in_valid = 4'b0010;
    tick();
    check("bp_capture", 32'(out_data), 32'hB1);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    #1;
    check("bp_ready_low", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_data", 32'(out_data), 32'hB1);
      check("bp_hold_valid", 32'(out_valid), 32'h1);
      check("bp_hold_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h4);
    tick();
    check("bp_next_data", 32'(out_data), 32'hC2);
    check("bp_next_chan", 32'(out_chan), 32'h2);

    // Forced select of channel 2
    mode = 1'b1;
    sel  = 2'd2;
    #1;
    check("fs_ready", 32'(in_ready), 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fs_data", 32'(out_data), 32'hC2);
      check("fs_chan", 32'(out_chan), 32'h2);
      check("fs_ready_loop", 32'(in_ready), 32'h4);
    end
    // sel changes while stalled must not disturb the held word
    out_ready = 1'b0;
    sel       = 2'd1;
    #1;
    check("fs_stall_ready", 32'(in_ready), 32'h0);
    tick();
    check("fs_stall_data", 32'(out_data), 32'hC2);
    check("fs_stall_chan", 32'(out_chan), 32'h2);
    mode      = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rr_after_fs_ready", 32'(in_ready), 32'h8);
    tick();
    check("rr_after_fs_chan", 32'(out_chan), 32'h3);
    check("rr_after_fs_data", 32'(out_data), 32'hD3);

    // Asynchronous reset between edges with a word in flight
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_out_data", 32'(out_data), 32'h00);
    check("arst_out_chan", 32'(out_chan), 32'h0);
`ifdef RR_MUX_ARBITER_STATS_EN
    check("arst_grant_count", 32'(|grant_count), 32'h0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("arst_first_ready", 32'(in_ready), 32'h1);
    tick();
    check("arst_first_chan", 32'(out_chan), 32'h0);
    check("arst_first_data", 32'(out_data), 32'hA0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Parametrised successor to the team's 4:1 byte selector: N channels of WIDTH bits, merged onto one registered output stream.
- Each input channel and the output use a valid/ready handshake.
- Two modes, chosen by the `mode` input:
  - mode 0: round-robin arbitration among valid channels.
  - mode 1: forced select, where only channel `sel` may pass.
- Sits between multiple producers and one downstream consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- N, 4, number of input channels (2..16).
- SEL_W, $clog2(N), width of sel and out_chan. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational, one-hot or zero.
- mode  input  1  0 = round-robin, 1 = forced select.
- sel  input  SEL_W  channel index used when mode=1.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_chan  output  SEL_W  index of the channel whose data is in the output register.

Behaviour:
- Reset (async assert, sync release):
  - out_data=0, out_valid=0, out_chan=0.
  - Round-robin pointer last_grant=N-1, so channel 0 has first priority.
- load = ~out_valid | out_ready. The output register may capture only when load=1.
- Eligibility:
  - mode 0: all channels with in_valid=1.
  - mode 1: only channel sel, if in_valid[sel]=1. If sel>=N, no channel is eligible.
- Round-robin search order: last_grant+1, last_grant+2, ..., wrapping modulo N. The first eligible channel wins.
- Grant: in_ready[g]=1 only when load=1 and channel g wins. All other in_ready bits are 0. No in_ready is asserted when load=0.
- Transfer on channel g (in_valid[g] & in_ready[g]). At the next edge:
  - out_data <= channel g data.
  - out_chan <= g.
  - out_valid <= 1.
  - last_grant <= g. This update happens in both modes.
- Drain with no new winner: if out_ready=1, out_valid=1 and there is no transfer, then out_valid <= 0. out_data and out_chan hold their values.
- Back-to-back: drain and capture in the same cycle is allowed, giving full throughput of 1 word/cycle.
- Latency: input accepted at edge k appears on out_* after edge k, i.e. 1 cycle.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_chan are held stable.
- Changing mode/sel while the output is stalled affects only the next arbitration, never the held word.
- Fairness: with all N channels continuously valid and out_ready=1 in mode 0, grants are 0,1,...,N-1,0,... with no gaps.
- Reset asserted mid-transfer: outputs clear immediately. The in-flight word is dropped.

Optional Feature:
- Macro: RR_MUX_ARBITER_STATS_EN.
- Defined:
  - Adds output port grant_count, width N*16.
  - Holds one 16-bit counter per channel, incremented on each transfer from that channel.
  - Counters wrap 0xFFFF->0 and reset to 0 on rst.
  - Add input port stats_clr (1 bit). stats_clr=1 synchronously zeroes all counters, taking priority over an increment in the same cycle.
- Undefined: ports and counters are absent. Data-path behaviour is identical.

Test Plan (WIDTH=8, N=4):
- Reset, then idle: after rst, out_valid=0, out_data=0x00, in_ready=4'b0000 with in_valid=0.
- Round-robin fairness: mode=0, all in_valid=1, data 0xA0/0xB1/0xC2/0xD3, out_ready=1 for 8 cycles.
  - Required: out_chan sequence 0,1,2,3,0,1,2,3.
  - Required: out_data sequence 0xA0,0xB1,0xC2,0xD3 repeating.
- Skip idle channels: mode=0, only channels 1 and 3 valid.
  - Required: grants alternate 1,3,1,3.
  - Required: in_ready[0] and in_ready[2] stay 0.
- Backpressure: out_ready=0 for 3 cycles after the first capture of 0xB1.
  - Required: out_data=0xB1 and out_valid=1 held throughout, in_ready=0.
  - Required: after out_ready=1, next word on the following edge.
- Forced select: mode=1, sel=2, all valid.
  - Required: only 0xC2 passes; in_ready=4'b0100 whenever load=1.
  - Then mode=0: the next grant is channel 3.
- Async reset mid-stream: assert rst between clock edges while out_valid=1.
  - Required: out_valid=0 immediately, with no clock edge.
  - Required: after release, the first grant goes to channel 0.
  - With RR_MUX_ARBITER_STATS_EN: grant_count=0.
